// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//  - uart_state_e : 4-bit frame-state encoding (also exported on d_state)
//  - tick_w       : width of a counter that covers 0..osr-1
//  - bit_cnt_w    : width of the per-phase bit counter
//  - frame_ticks  : total i_en ticks in one frame
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA  = 4'd2,
    ST_STOP  = 4'd3
  } uart_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned tick_w(input int unsigned osr);
    return (osr > 1) ? $clog2(osr) : 1;
  endfunction

  function automatic int unsigned bit_cnt_w(input int unsigned start_bits,
                                            input int unsigned data_bits,
                                            input int unsigned stop_bits);
    return $clog2(max3(start_bits, data_bits, stop_bits)) + 1;
  endfunction

  function automatic int unsigned frame_ticks(input int unsigned start_bits,
                                              input int unsigned data_bits,
                                              input int unsigned stop_bits,
                                              input int unsigned osr);
    return (start_bits + data_bits + stop_bits) * osr;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts i_en ticks within one bit period of OSR ticks.
// Ports:
//  i_clk      clock
//  i_rst      synchronous active-high reset (count -> 0)
//  i_clr      hold the count at 0 (used while no frame is running)
//  i_en       tick enable; the count only moves on ticks
//  o_bit_end  high on the tick that completes the current bit
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OSR = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int unsigned TW = tick_w(OSR);
  localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);

  logic [TW-1:0] tick_d, tick_q;

  always_comb begin
    // >= rather than == so a corrupted count past the terminal value
    // still ends the bit instead of wrapping through the full range.
    o_bit_end = i_en && (tick_q >= TICK_LAST);
    tick_d    = tick_q;
    if (i_clr) begin
      tick_d = '0;
    end else if (i_en) begin
      tick_d = o_bit_end ? '0 : tick_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one DATA-bit word per frame: START start bits,
// data LSB-first, STOP stop bits, each bit lasting OSR i_en ticks.
// Ports:
//  i_divided_clk  oversampled clock (only clock)
//  i_rst          synchronous active-high reset; aborts any frame
//  i_en           tick enable; frame timing advances only when high
//  i_data         word to send, sampled only on accept
//  i_valid        i_data valid; accepted when o_ready is high
//  o_ready        high while idle (word accepted on this edge if i_valid)
//  o_tx           registered serial line
//  o_busy         frame in progress
//  o_done         one-clock pulse when the last stop tick completes
//  d_state        current state encoding (debug)
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned START    = 1,
  parameter int unsigned DATA     = 8,
  parameter int unsigned STOP     = 2,
  parameter int unsigned OSR      = 16,
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic            i_divided_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [DATA-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_done,
  output logic [3:0]      d_state
);

  localparam int unsigned BW = bit_cnt_w(START, DATA, STOP);
  localparam logic [BW-1:0] START_LAST = BW'(START - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP - 1);

  uart_state_e     state_d, state_q;
  logic [DATA-1:0] shift_d, shift_q;
  logic [BW-1:0]   bit_cnt_d, bit_cnt_q;
  logic            tx_d, tx_q;
  logic            ready_d, ready_q;
  logic            busy_d, busy_q;
  logic            done_d, done_q;

  logic            running;
  logic            bit_end;
  logic [DATA-1:0] shift_next;

  // Timer only runs inside a frame; otherwise it is held at zero so the
  // first tick after accept is tick 0 of the first start bit.
  assign running = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_STOP);

  uart_bit_timer #(
    .OSR (OSR)
  ) u_bit_timer (
    .i_clk     (i_divided_clk),
    .i_rst     (i_rst),
    .i_clr     (!running),
    .i_en      (i_en && running),
    .o_bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_next = shift_q >> 1;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        tx_d    = IDLE_LVL;
        if (i_valid && ready_q) begin
          shift_d   = i_data;
          tx_d      = ~IDLE_LVL;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          if (bit_cnt_q >= START_LAST) begin
            bit_cnt_d = '0;
            tx_d      = shift_q[0];
            state_d   = ST_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_next;
          if (bit_cnt_q >= DATA_LAST) begin
            bit_cnt_d = '0;
            tx_d      = IDLE_LVL;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_next[0];
          end
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q >= STOP_LAST) begin
            bit_cnt_d = '0;
            tx_d      = IDLE_LVL;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        tx_d      = IDLE_LVL;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_divided_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LVL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign d_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int unsigned OSR   = 16;
  localparam int unsigned START = 1;
  localparam int unsigned DATA  = 8;
  localparam int unsigned STOP  = 2;
  localparam int unsigned FRAME = (START + DATA + STOP) * OSR;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;
  logic [3:0] dstate;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .START    (START),
    .DATA     (DATA),
    .STOP     (STOP),
    .OSR      (OSR),
    .IDLE_LVL (1'b1)
  ) dut (
    .i_divided_clk (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_data        (data),
    .i_valid       (valid),
    .o_ready       (ready),
    .o_tx          (tx),
    .o_busy        (busy),
    .o_done        (done),
    .d_state       (dstate)
  );

  typedef struct {
    logic [7:0]  word;
    int unsigned div;
    int unsigned exp_clocks;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal line level during tick k after accept (k=0 is the first tick).
  function automatic logic exp_level(input logic [7:0] w, input int unsigned k);
    int unsigned b;
    b = k / OSR;
    if (b < START) return 1'b0;
    if (b < START + DATA) return w[b - START];
    return 1'b1;
  endfunction

  task automatic do_accept(input logic [7:0] w, input int unsigned div);
    int unsigned waited = 0;
    while (!ready && waited < 1000) begin
      valid = 1'b0;
      en    = 1'b1;
      step();
      waited++;
    end
    check("ready_before_accept", 32'(ready), 32'd1);
    valid = 1'b1;
    data  = w;
    en    = (div == 1);   // with a divider, accept lands on a non-tick clock
    step();
    check("accept_state", {25'd0, busy, ready, tx, dstate}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd1});
  endtask

  task automatic watch_frame(input logic [7:0] w, input int unsigned div,
                             input logic [7:0] mid_data, input logic hold,
                             output int unsigned clocks);
    int unsigned k = 0;
    int unsigned c = 0;
    int unsigned ndone = 0;
    int unsigned done_k = 0;
    int unsigned bad_k = 0;
    int unsigned b;
    logic        wave_ok = 1'b1;
    logic [7:0]  dec = '0;
    logic        e_tx, e_busy, e_ready;
    while (k < FRAME && c < FRAME * div + 20) begin
      en    = ((c % div) == div - 1);
      valid = hold ? 1'b1 : 1'($urandom % 2);
      if (c == (FRAME * div) / 2) data = mid_data;
      step();
      c++;
      if (en) k++;
      if (done) begin
        ndone++;
        done_k = k;
      end
      e_tx    = (k < FRAME) ? exp_level(w, k) : 1'b1;
      e_busy  = (k < FRAME);
      e_ready = (k >= FRAME);
      if (wave_ok && (tx !== e_tx || busy !== e_busy || ready !== e_ready)) begin
        wave_ok = 1'b0;
        bad_k   = k;
      end
      if (en && (k % OSR) == OSR / 2) begin
        b = k / OSR;
        if (b >= START && b < START + DATA) dec[b - START] = tx;
      end
    end
    clocks = c;
    if (!wave_ok) $display("  line diverged from ideal frame at tick %0d (word %02h)", bad_k, w);
    check("line_waveform", 32'(wave_ok), 32'd1);
    check("done_count", ndone, 32'd1);
    check("done_tick", done_k, FRAME);
    check("decoded_word", 32'(dec), 32'(w));
    if (!hold) valid = 1'b0;
  endtask

  task automatic after_done();
    valid = 1'b0;
    en    = 1'b1;
    step();
    check("idle_after_done", {28'd0, ready, done, busy, tx}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    vec_t        vecs[4];
    int unsigned clocks;
    int unsigned ndone;
    int unsigned line_low;
    int unsigned div;
    logic [7:0]  w;

    vecs[0] = '{word: 8'hA5, div: 1, exp_clocks: 176};
    vecs[1] = '{word: 8'h3C, div: 4, exp_clocks: 704};
    vecs[2] = '{word: 8'h81, div: 1, exp_clocks: 176};
    vecs[3] = '{word: 8'h5A, div: 2, exp_clocks: 352};

    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (3) step();
    check("reset_outputs", {24'd0, tx, ready, busy, done, dstate}, {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
    rst = 1'b0;
    step();
    check("idle_after_reset", {24'd0, tx, ready, busy, done, dstate}, {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});

    foreach (vecs[i]) begin
      do_accept(vecs[i].word, vecs[i].div);
      watch_frame(vecs[i].word, vecs[i].div, 8'($urandom), 1'b0, clocks);
      check("frame_clocks", clocks, vecs[i].exp_clocks);
      after_done();
    end

    // Held i_valid: 0x00 then 0xFF back-to-back, i_data changed mid-frame.
    do_accept(8'h00, 1);
    watch_frame(8'h00, 1, 8'hFF, 1'b1, clocks);
    step();
    check("back_to_back_accept", {25'd0, busy, ready, tx, dstate}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd1});
    watch_frame(8'hFF, 1, 8'($urandom), 1'b0, clocks);
    after_done();

    // Reset 50 ticks into a frame.
    do_accept(8'h66, 1);
    valid = 1'b0;
    en    = 1'b1;
    repeat (50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midframe_reset", {24'd0, tx, ready, busy, done, dstate}, {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
    ndone    = 0;
    line_low = 0;
    repeat (200) begin
      step();
      if (done) ndone++;
      if (!tx) line_low++;
    end
    check("no_done_after_abort", ndone, 32'd0);
    check("line_idle_after_abort", line_low, 32'd0);
    do_accept(8'h81, 1);
    watch_frame(8'h81, 1, 8'($urandom), 1'b0, clocks);
    after_done();

    // Randomized words and tick rates.
    repeat (8) begin
      w   = 8'($urandom);
      div = $urandom_range(1, 3);
      do_accept(w, div);
      watch_frame(w, div, 8'($urandom), 1'b0, clocks);
      check("rand_frame_clocks", clocks, FRAME * div);
      after_done();
    end

    // Full byte sweep decoded by the bench's line sampler.
    for (int unsigned v = 0; v < 256; v++) begin
      do_accept(8'(v), 1);
      watch_frame(8'(v), 1, 8'($urandom), 1'b0, clocks);
      after_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
